// File: rtl/tlb_unit.sv
// Fully-associative joint TLB with two combinational search ports and
// single-cycle registered probe (TLBP) and read (TLBR) responses for CP0.
module tlb_unit #(
  parameter int TLBNUM = 16,
  localparam int IW = $clog2(TLBNUM)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [18:0]   s0_vpn2,
  input  logic          s0_odd,
  input  logic [7:0]    s0_asid,
  output logic          s0_found,
  output logic [IW-1:0] s0_index,
  output logic [19:0]   s0_pfn,
  output logic [2:0]    s0_c,
  output logic          s0_d,
  output logic          s0_v,
  input  logic [18:0]   s1_vpn2,
  input  logic          s1_odd,
  input  logic [7:0]    s1_asid,
  output logic          s1_found,
  output logic [IW-1:0] s1_index,
  output logic [19:0]   s1_pfn,
  output logic [2:0]    s1_c,
  output logic          s1_d,
  output logic          s1_v,
  input  logic          we,
  input  logic [IW-1:0] w_index,
  input  logic [77:0]   w_entry,
  input  logic          tlbp_req,
  input  logic [31:0]   tlbp_entryhi,
  output logic          tlbp_wen,
  output logic [31:0]   tlbp_index,
  input  logic          tlbr_req,
  input  logic [IW-1:0] r_index,
  output logic          tlbr_wen,
  output logic [77:0]   tlbr_entry
);

  // Entry layout: [77:59] vpn2, [58:51] asid, [50] g, [49:25] even page, [24:0] odd page
  logic [77:0]       entry_q [TLBNUM];
  logic [TLBNUM-1:0] e_q;

  logic [TLBNUM-1:0] m0, m1, mp;
  logic [IW-1:0]     i0, i1, ip;
  logic [24:0]       pg0, pg1;
  logic              unused_entryhi;

  assign unused_entryhi = ^tlbp_entryhi[12:8];

  always_comb begin
    m0 = '0;
    m1 = '0;
    mp = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      m0[i] = e_q[i] && (s0_vpn2 == entry_q[i][77:59]) &&
              (entry_q[i][50] || (s0_asid == entry_q[i][58:51]));
      m1[i] = e_q[i] && (s1_vpn2 == entry_q[i][77:59]) &&
              (entry_q[i][50] || (s1_asid == entry_q[i][58:51]));
      mp[i] = e_q[i] && (tlbp_entryhi[31:13] == entry_q[i][77:59]) &&
              (entry_q[i][50] || (tlbp_entryhi[7:0] == entry_q[i][58:51]));
    end
  end

  // Scan from the top down so the lowest matching index is the one kept.
  always_comb begin
    i0 = '0;
    i1 = '0;
    ip = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (m0[i]) i0 = IW'(i);
      if (m1[i]) i1 = IW'(i);
      if (mp[i]) ip = IW'(i);
    end
  end

  assign s0_found = |m0;
  assign s1_found = |m1;
  assign s0_index = i0;
  assign s1_index = i1;

  always_comb begin
    pg0 = '0;
    pg1 = '0;
    if (s0_found) pg0 = s0_odd ? entry_q[i0][24:0] : entry_q[i0][49:25];
    if (s1_found) pg1 = s1_odd ? entry_q[i1][24:0] : entry_q[i1][49:25];
  end

  assign s0_pfn = pg0[24:5];
  assign s0_c   = pg0[4:2];
  assign s0_d   = pg0[1];
  assign s0_v   = pg0[0];
  assign s1_pfn = pg1[24:5];
  assign s1_c   = pg1[4:2];
  assign s1_d   = pg1[1];
  assign s1_v   = pg1[0];

  // Entry payload is not reset; only the present bits are.
  always_ff @(posedge clk) begin
    if (resetn && we) entry_q[w_index] <= w_entry;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      e_q        <= '0;
      tlbp_wen   <= 1'b0;
      tlbp_index <= '0;
      tlbr_wen   <= 1'b0;
      tlbr_entry <= '0;
    end else begin
      if (we) e_q[w_index] <= 1'b1;
      tlbp_wen <= tlbp_req;
      if (tlbp_req) tlbp_index <= {~(|mp), {(31 - IW){1'b0}}, ip};
      tlbr_wen <= tlbr_req;
      if (tlbr_req) tlbr_entry <= e_q[r_index] ? entry_q[r_index] : '0;
    end
  end

endmodule

// File: tb/tb_tlb_unit.sv
// Scoreboard bench for tlb_unit: probe/read responses are queued when issued and
// checked by a monitor on each strobe; search ports are checked directly.
module tb_tlb_unit;

  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic [18:0]   s0_vpn2, s1_vpn2;
  logic          s0_odd, s1_odd;
  logic [7:0]    s0_asid, s1_asid;
  logic          s0_found, s1_found, s0_d, s1_d, s0_v, s1_v;
  logic [IW-1:0] s0_index, s1_index;
  logic [19:0]   s0_pfn, s1_pfn;
  logic [2:0]    s0_c, s1_c;
  logic          we;
  logic [IW-1:0] w_index;
  logic [77:0]   w_entry;
  logic          tlbp_req;
  logic [31:0]   tlbp_entryhi;
  logic          tlbp_wen;
  logic [31:0]   tlbp_index;
  logic          tlbr_req;
  logic [IW-1:0] r_index;
  logic          tlbr_wen;
  logic [77:0]   tlbr_entry;

  tlb_unit #(.TLBNUM(16)) dut (
    .clk(clk), .resetn(resetn),
    .s0_vpn2(s0_vpn2), .s0_odd(s0_odd), .s0_asid(s0_asid), .s0_found(s0_found),
    .s0_index(s0_index), .s0_pfn(s0_pfn), .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
    .s1_vpn2(s1_vpn2), .s1_odd(s1_odd), .s1_asid(s1_asid), .s1_found(s1_found),
    .s1_index(s1_index), .s1_pfn(s1_pfn), .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
    .we(we), .w_index(w_index), .w_entry(w_entry),
    .tlbp_req(tlbp_req), .tlbp_entryhi(tlbp_entryhi), .tlbp_wen(tlbp_wen),
    .tlbp_index(tlbp_index),
    .tlbr_req(tlbr_req), .r_index(r_index), .tlbr_wen(tlbr_wen), .tlbr_entry(tlbr_entry)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [31:0] val; } p_exp_t;
  typedef struct { int due; logic [77:0] val; } r_exp_t;
  p_exp_t p_q[$];
  r_exp_t r_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Hand-built entries: {vpn2, asid, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1}
  localparam logic [77:0] E3  = {19'h12345, 8'h05, 1'b0, 20'hABCDE, 3'd3, 1'b1, 1'b1,
                                 20'h11111, 3'd2, 1'b0, 1'b1};
  localparam logic [77:0] E3G = {19'h12345, 8'h05, 1'b1, 20'hABCDE, 3'd3, 1'b1, 1'b1,
                                 20'h11111, 3'd2, 1'b0, 1'b1};
  localparam logic [77:0] E5  = {19'h2AAAA, 8'h09, 1'b0, 20'h00042, 3'd2, 1'b0, 1'b1,
                                 20'h00043, 3'd2, 1'b1, 1'b0};

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every strobe must match the head of its queue in both value and cycle.
  always @(negedge clk) begin
    if (tlbp_wen) begin
      if (p_q.size() == 0) chk("tlbp_unexpected_strobe", 80'd1, 80'd0);
      else begin
        p_exp_t e;
        e = p_q.pop_front();
        chk("tlbp_latency", 80'(cyc), 80'(e.due));
        chk("tlbp_index", 80'(tlbp_index), 80'(e.val));
      end
    end
    if (tlbr_wen) begin
      if (r_q.size() == 0) chk("tlbr_unexpected_strobe", 80'd1, 80'd0);
      else begin
        r_exp_t e;
        e = r_q.pop_front();
        chk("tlbr_latency", 80'(cyc), 80'(e.due));
        chk("tlbr_entry", 80'(tlbr_entry), 80'(e.val));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input logic [18:0] vpn2, input logic [7:0] asid, input logic [31:0] exp);
    tlbp_req = 1'b1;
    tlbp_entryhi = {vpn2, 5'b0, asid};
    p_q.push_back('{due: cyc + 1, val: exp});
  endtask

  task automatic rd(input logic [IW-1:0] idx, input logic [77:0] exp);
    tlbr_req = 1'b1;
    r_index = idx;
    r_q.push_back('{due: cyc + 1, val: exp});
  endtask

  task automatic look0(input string name, input logic [18:0] vpn2, input logic odd,
                       input logic [7:0] asid, input logic [29:0] exp);
    s0_vpn2 = vpn2; s0_odd = odd; s0_asid = asid;
    #1;
    chk(name, 80'({s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v}), 80'(exp));
  endtask

  task automatic look1(input string name, input logic [18:0] vpn2, input logic odd,
                       input logic [7:0] asid, input logic [29:0] exp);
    s1_vpn2 = vpn2; s1_odd = odd; s1_asid = asid;
    #1;
    chk(name, 80'({s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v}), 80'(exp));
  endtask

  initial begin
    resetn = 1'b0; we = 1'b0; w_index = '0; w_entry = '0;
    tlbp_req = 1'b0; tlbp_entryhi = '0; tlbr_req = 1'b0; r_index = '0;
    s0_vpn2 = '0; s0_odd = 1'b0; s0_asid = '0;
    s1_vpn2 = '0; s1_odd = 1'b0; s1_asid = '0;
    tick(); tick();
    chk("rst_tlbp_wen", 80'(tlbp_wen), 80'd0);
    chk("rst_tlbp_index", 80'(tlbp_index), 80'd0);
    chk("rst_tlbr_wen", 80'(tlbr_wen), 80'd0);
    chk("rst_tlbr_entry", 80'(tlbr_entry), 80'd0);
    resetn = 1'b1;
    tick();

    // Empty TLB: lookup and probe both miss.
    look0("empty_s0", 19'h12345, 1'b0, 8'h05, {1'b0, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0});
    probe(19'h12345, 8'h05, 32'h8000_0000);
    tick();
    tlbp_req = 1'b0;

    we = 1'b1; w_index = 4'd3; w_entry = E3;
    tick();
    we = 1'b0;
    look0("idx3_even", 19'h12345, 1'b0, 8'h05, {1'b1, 4'd3, 20'hABCDE, 3'd3, 1'b1, 1'b1});
    look1("idx3_odd", 19'h12345, 1'b1, 8'h05, {1'b1, 4'd3, 20'h11111, 3'd2, 1'b0, 1'b1});
    look0("asid_miss", 19'h12345, 1'b0, 8'h06, {1'b0, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0});
    look1("vpn_miss", 19'h12344, 1'b0, 8'h05, {1'b0, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0});

    // Back-to-back reads: written entry, then an unwritten one.
    rd(4'd3, E3);
    tick();
    rd(4'd7, 78'd0);
    tick();
    tlbr_req = 1'b0;

    we = 1'b1; w_index = 4'd3; w_entry = E3G;
    tick();
    we = 1'b0;
    look1("global_hit", 19'h12345, 1'b0, 8'h7F, {1'b1, 4'd3, 20'hABCDE, 3'd3, 1'b1, 1'b1});

    we = 1'b1; w_index = 4'd1; w_entry = E3G;
    tick();
    we = 1'b0;
    look0("dup_lowest_s0", 19'h12345, 1'b0, 8'h05, {1'b1, 4'd1, 20'hABCDE, 3'd3, 1'b1, 1'b1});
    look1("dup_lowest_s1", 19'h12345, 1'b1, 8'h7F, {1'b1, 4'd1, 20'h11111, 3'd2, 1'b0, 1'b1});
    probe(19'h12345, 8'h05, 32'h0000_0001);
    tick();
    tlbp_req = 1'b0;

    // Probe, read and write of idx5 together: responses see pre-write contents.
    we = 1'b1; w_index = 4'd5; w_entry = E5;
    probe(19'h2AAAA, 8'h09, 32'h8000_0000);
    rd(4'd5, 78'd0);
    tick();
    we = 1'b0;
    probe(19'h2AAAA, 8'h09, 32'h0000_0005);
    rd(4'd5, E5);
    tick();
    tlbp_req = 1'b0; tlbr_req = 1'b0;
    look1("v0_still_found", 19'h2AAAA, 1'b1, 8'h09, {1'b1, 4'd5, 20'h00043, 3'd2, 1'b1, 1'b0});
    tick(); tick();
    chk("tlbp_index_hold", 80'(tlbp_index), 80'h5);
    chk("tlbp_wen_drop", 80'(tlbp_wen), 80'd0);
    chk("tlbr_entry_hold", 80'(tlbr_entry), 80'(E5));

    // Reset coincident with a probe request drops the request and clears E.
    resetn = 1'b0;
    tlbp_req = 1'b1; tlbp_entryhi = {19'h2AAAA, 5'b0, 8'h09};
    tick();
    resetn = 1'b1; tlbp_req = 1'b0;
    chk("rst_drop_wen", 80'(tlbp_wen), 80'd0);
    chk("rst_drop_index", 80'(tlbp_index), 80'd0);
    tick();
    chk("rst_drop_wen_next", 80'(tlbp_wen), 80'd0);
    look0("post_rst_miss0", 19'h12345, 1'b0, 8'h05, {1'b0, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0});
    look1("post_rst_miss1", 19'h2AAAA, 1'b1, 8'h09, {1'b0, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0});
    rd(4'd3, 78'd0);
    tick();
    tlbr_req = 1'b0;

    we = 1'b1; w_index = 4'd5; w_entry = E5;
    tick();
    we = 1'b0;
    look1("rewrite_hit", 19'h2AAAA, 1'b0, 8'h09, {1'b1, 4'd5, 20'h00042, 3'd2, 1'b0, 1'b1});

    tick(); tick(); tick();
    chk("tlbp_queue_drained", 80'(p_q.size()), 80'd0);
    chk("tlbr_queue_drained", 80'(r_q.size()), 80'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1);
  end

endmodule
